// File: rtl/agm_pingpong.sv
// Ping-pong line-buffer address generator: linear or strided writes into
// one bank while the opposite bank is read out sequentially.
module agm_pingpong #(
  parameter int AW          = 11,
  parameter int STRIDE_LOG2 = 3,
  parameter int RD_AW       = 8,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [AW:0]      wr_addr,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [RD_AW:0]   rd_addr,
  output logic             bank_done,
  output logic [CNT_W-1:0] frame_cnt
);

  logic [AW-1:0]    c;
  logic             wr_bank;
  logic             mode_q;
  logic [1:0]       full;
  logic [1:0]       full_d;
  logic [RD_AW-1:0] r;
  logic             rd_bank;
  logic [AW-1:0]    wr_off;
  logic             wr_fire;
  logic             rd_fire;
  logic             c_last;
  logic             r_last;

  assign wr_ready = !full[wr_bank];
  assign wr_fire  = wr_valid && wr_ready;
  assign c_last   = &c;

  assign rd_valid = full[rd_bank];
  assign rd_fire  = rd_valid && rd_ready;
  assign r_last   = &r;

  // Strided order rotates the counter so its low bits become the stride index.
  assign wr_off = mode_q
    ? {c[AW-STRIDE_LOG2-1:0], c[AW-1:AW-STRIDE_LOG2]}
    : c;

  assign wr_addr = {wr_bank, wr_off};
  assign rd_addr = {rd_bank, r};

  // Fill and drain never hit the same bank in one cycle.
  always_comb begin
    full_d = full;
    if (wr_fire && c_last)
      full_d[wr_bank] = 1'b1;
    if (rd_fire && r_last)
      full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= full_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      wr_bank   <= 1'b0;
      mode_q    <= 1'b0;
      frame_cnt <= '0;
      bank_done <= 1'b0;
    end else begin
      bank_done <= wr_fire && c_last;
      if (wr_fire) begin
        c <= c + 1'b1;
        if (c == '0)
          mode_q <= mode;
        if (c_last) begin
          wr_bank   <= ~wr_bank;
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      r <= r + 1'b1;
      if (r_last)
        rd_bank <= ~rd_bank;
    end
  end

endmodule
